// File: rtl/sipiso_alu_p.sv
// Serial-in A / parallel-in B ALU with a serial, LSB-first W+1 bit result.
// A streams in after STARTA; B may arrive before, with, or after A completes.
module sipiso_alu_p #(
  parameter int W = 4
) (
  input  logic         CLK,
  input  logic         RESET_N,
  input  logic         STARTA,
  input  logic         A,
  input  logic [1:0]   OP,
  input  logic         LOADB,
  input  logic [W-1:0] B,
  output logic         STARTC,
  output logic         C,
  output logic         BUSY
);

  localparam int            CW     = $clog2(W + 1);
  localparam logic [CW-1:0] LAST_A = CW'(W - 1);
  localparam logic [CW-1:0] LAST_C = CW'(W);

  typedef enum logic [1:0] {IDLE, SHIFT_A, WAIT_B, SHIFT_C} state_t;

  state_t        state;
  state_t        next_state;
  logic [W-1:0]  a_sr;
  logic [W-1:0]  b_reg;
  logic [W-1:0]  a_full;
  logic [W-1:0]  b_eff;
  logic [1:0]    op_reg;
  logic          b_valid;
  logic [CW-1:0] cnt;
  logic [W:0]    res_sr;
  logic [W:0]    result;
  logic          a_done;
  logic          start_c;
  logic          load_b_ok;
  logic          startc_d;
  logic          c_d;
  logic          busy_d;

  assign load_b_ok = LOADB && (state != SHIFT_C);
  assign a_done    = (state == SHIFT_A) && (cnt == LAST_A);
  // The operands are looked at one cycle early so bit 0 of C can leave
  // the very next cycle: the final A bit and a same-cycle B are bypassed.
  assign a_full    = (state == SHIFT_A) ? {A, a_sr[W-1:1]} : a_sr;
  assign b_eff     = LOADB ? B : b_reg;
  assign start_c   = (a_done && (b_valid || LOADB)) || ((state == WAIT_B) && LOADB);

  // W+1 bit arithmetic: the top bit is the carry on add and the borrow on sub.
  always_comb begin
    result = '0;
    case (op_reg)
      2'b00:   result = {1'b0, a_full} + {1'b0, b_eff};
      2'b01:   result = {1'b0, a_full} - {1'b0, b_eff};
      2'b10:   result = {1'b0, a_full & b_eff};
      default: result = {1'b0, a_full ^ b_eff};
    endcase
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (STARTA) next_state = SHIFT_A;
      SHIFT_A: if (a_done) next_state = start_c ? SHIFT_C : WAIT_B;
      WAIT_B:  if (LOADB) next_state = SHIFT_C;
      SHIFT_C: if (cnt == LAST_C) next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  always_comb begin
    startc_d = start_c;
    c_d      = 1'b0;
    if (start_c) begin
      c_d = result[0];
    end else if ((state == SHIFT_C) && (cnt != LAST_C)) begin
      c_d = res_sr[0];
    end
    busy_d = (next_state != IDLE);
  end

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state   <= IDLE;
      a_sr    <= '0;
      b_reg   <= '0;
      op_reg  <= '0;
      b_valid <= 1'b0;
      cnt     <= '0;
      res_sr  <= '0;
      STARTC  <= 1'b0;
      C       <= 1'b0;
      BUSY    <= 1'b0;
    end else begin
      state  <= next_state;
      STARTC <= startc_d;
      C      <= c_d;
      BUSY   <= busy_d;
      if (load_b_ok) begin
        b_reg   <= B;
        b_valid <= 1'b1;
      end
      case (state)
        IDLE: begin
          if (STARTA) begin
            a_sr   <= {A, a_sr[W-1:1]};
            op_reg <= OP;
            cnt    <= CW'(1);
          end
        end
        SHIFT_A: begin
          a_sr <= {A, a_sr[W-1:1]};
          cnt  <= cnt + CW'(1);
        end
        SHIFT_C: begin
          res_sr <= res_sr >> 1;
          cnt    <= cnt + CW'(1);
          if (cnt == LAST_C) begin
            cnt     <= '0;
            b_valid <= 1'b0;
          end
        end
        default: ;
      endcase
      // Bit 0 goes straight to C; the remaining bits wait in res_sr.
      if (start_c) begin
        res_sr <= result >> 1;
        cnt    <= '0;
      end
    end
  end

endmodule

// File: tb/tb_sipiso_alu_p.sv
// Bench for sipiso_alu_p: W=4 vector table plus hand sequences, and a W=8
// instance for back-to-back operations. Results are scored by serial monitors.
module tb_sipiso_alu_p;

  logic       CLK = 1'b0;
  logic       RESET_N;
  logic       a_in;
  logic [1:0] op_in;
  logic [7:0] b_in;
  logic       starta4, loadb4, starta8, loadb8;
  logic       startc4, c4, busy4;
  logic       startc8, c8, busy8;

  int errors = 0;
  int checks = 0;
  int cyc    = 0;

  always #5 CLK = ~CLK;
  always @(posedge CLK) cyc <= cyc + 1;

  sipiso_alu_p #(.W(4)) dut4 (
    .CLK(CLK), .RESET_N(RESET_N), .STARTA(starta4), .A(a_in), .OP(op_in),
    .LOADB(loadb4), .B(b_in[3:0]), .STARTC(startc4), .C(c4), .BUSY(busy4)
  );

  sipiso_alu_p #(.W(8)) dut8 (
    .CLK(CLK), .RESET_N(RESET_N), .STARTA(starta8), .A(a_in), .OP(op_in),
    .LOADB(loadb8), .B(b_in), .STARTC(startc8), .C(c8), .BUSY(busy8)
  );

  typedef struct {
    logic [1:0] op;
    logic [3:0] a;
    logic [3:0] b;
    logic       preload;
    logic [4:0] exp_r;
  } vec_t;

  localparam int NV = 10;
  vec_t vecs [NV];

  logic [8:0] exp4_q[$];
  logic [8:0] exp8_q[$];
  logic [8:0] cur_exp4, got4, cur_exp8, got8;
  int col4 = 0, done4 = 0;
  int col8 = 0, done8 = 0;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic failNow(input string name);
    checks++;
    errors++;
    $display("[TB] FAIL %s", name);
  endtask

  // Each STARTC pops the next expected result; C bits are then assembled LSB first.
  always @(negedge CLK) begin
    if (!RESET_N) begin
      col4 = 0;
    end else begin
      if (startc4) begin
        if (col4 != 0) failNow("startc4_during_result");
        if (exp4_q.size() == 0) begin
          failNow("startc4_unexpected");
          col4 = 0;
        end else begin
          cur_exp4 = exp4_q.pop_front();
          got4     = '0;
          got4[0]  = c4;
          col4     = 1;
        end
      end else if (col4 > 0) begin
        got4[col4] = c4;
        col4++;
      end
      if (col4 == 5) begin
        checkOutput("result_w4", 32'(got4), 32'(cur_exp4));
        col4 = 0;
        done4++;
      end
    end
  end

  always @(negedge CLK) begin
    if (!RESET_N) begin
      col8 = 0;
    end else begin
      if (startc8) begin
        if (col8 != 0) failNow("startc8_during_result");
        if (exp8_q.size() == 0) begin
          failNow("startc8_unexpected");
          col8 = 0;
        end else begin
          cur_exp8 = exp8_q.pop_front();
          got8     = '0;
          got8[0]  = c8;
          col8     = 1;
        end
      end else if (col8 > 0) begin
        got8[col8] = c8;
        col8++;
      end
      if (col8 == 9) begin
        checkOutput("result_w8", 32'(got8), 32'(cur_exp8));
        col8 = 0;
        done8++;
      end
    end
  end

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  // Starts in the current cycle t and returns in cycle t+w.
  task automatic sendA(input int w, input logic [7:0] a, input logic [1:0] op,
                       input logic with_b, input logic [7:0] b);
    a_in  = a[0];
    op_in = op;
    if (with_b) b_in = b;
    if (w == 4) begin
      starta4 = 1'b1;
      loadb4  = with_b;
    end else begin
      starta8 = 1'b1;
      loadb8  = with_b;
    end
    for (int i = 1; i < w; i++) begin
      step();
      starta4 = 1'b0; starta8 = 1'b0;
      loadb4  = 1'b0; loadb8  = 1'b0;
      a_in    = a[i];
    end
    step();
    a_in = 1'b0;
  endtask

  task automatic waitDone4(input int target);
    int n = 0;
    while (done4 < target && n < 40) begin
      @(negedge CLK);
      n++;
    end
    if (done4 < target) failNow("timeout_w4_result");
    step();
  endtask

  task automatic waitDone8(input int target);
    int n = 0;
    while (done8 < target && n < 60) begin
      @(negedge CLK);
      n++;
    end
    if (done8 < target) failNow("timeout_w8_result");
    step();
  endtask

  task automatic applyStimulus(input int i);
    int t;
    if (vecs[i].preload) begin
      loadb4 = 1'b1;
      b_in   = {4'h0, vecs[i].b};
      step();
      loadb4 = 1'b0;
      b_in   = 8'h00;
    end
    exp4_q.push_back(9'(vecs[i].exp_r));
    t = cyc;
    sendA(4, {4'h0, vecs[i].a}, vecs[i].op, !vecs[i].preload, {4'h0, vecs[i].b});
    @(negedge CLK);
    checkOutput($sformatf("v%0d_startc", i), 32'(startc4), 32'd1);
    checkOutput($sformatf("v%0d_startc_cycle", i), 32'(cyc - t), 32'd4);
    repeat (4) @(posedge CLK);
    @(negedge CLK);
    checkOutput($sformatf("v%0d_busy_last_bit", i), 32'(busy4), 32'd1);
    @(negedge CLK);
    checkOutput($sformatf("v%0d_busy_after", i), 32'(busy4), 32'd0);
    checkOutput($sformatf("v%0d_c_idle", i), 32'(c4), 32'd0);
    step();
  endtask

  initial begin
    int t;
    int seen;
    vecs[0] = '{op: 2'b01, a: 4'd3,  b: 4'd5,  preload: 1'b0, exp_r: 5'b11110};
    vecs[1] = '{op: 2'b00, a: 4'd11, b: 4'd6,  preload: 1'b1, exp_r: 5'b10001};
    vecs[2] = '{op: 2'b10, a: 4'hC,  b: 4'hA,  preload: 1'b0, exp_r: 5'b01000};
    vecs[3] = '{op: 2'b11, a: 4'hC,  b: 4'hA,  preload: 1'b1, exp_r: 5'b00110};
    vecs[4] = '{op: 2'b00, a: 4'd15, b: 4'd15, preload: 1'b0, exp_r: 5'b11110};
    vecs[5] = '{op: 2'b01, a: 4'd9,  b: 4'd9,  preload: 1'b1, exp_r: 5'b00000};
    vecs[6] = '{op: 2'b01, a: 4'd15, b: 4'd0,  preload: 1'b0, exp_r: 5'b01111};
    vecs[7] = '{op: 2'b00, a: 4'd0,  b: 4'd0,  preload: 1'b1, exp_r: 5'b00000};
    vecs[8] = '{op: 2'b01, a: 4'd0,  b: 4'd15, preload: 1'b0, exp_r: 5'b10001};
    vecs[9] = '{op: 2'b10, a: 4'd15, b: 4'd15, preload: 1'b1, exp_r: 5'b01111};

    RESET_N = 1'b0;
    a_in = 1'b0; op_in = 2'b00; b_in = 8'h00;
    starta4 = 1'b0; loadb4 = 1'b0; starta8 = 1'b0; loadb8 = 1'b0;
    repeat (3) @(posedge CLK);
    #1;
    checkOutput("reset_startc", 32'(startc4), 32'd0);
    checkOutput("reset_c", 32'(c4), 32'd0);
    checkOutput("reset_busy", 32'(busy4), 32'd0);
    checkOutput("reset_busy_w8", 32'(busy8), 32'd0);
    RESET_N = 1'b1;

    // The first vector starts in the release cycle, with B on the same strobe.
    for (int i = 0; i < NV; i++) applyStimulus(i);

    // Late B: A completes first, the unit parks until LOADB.
    sendA(4, 8'h02, 2'b00, 1'b0, 8'h00);
    @(negedge CLK);
    checkOutput("lateb_busy", 32'(busy4), 32'd1);
    checkOutput("lateb_no_startc", 32'(startc4), 32'd0);
    repeat (3) @(posedge CLK);
    @(negedge CLK);
    checkOutput("lateb_still_waiting", 32'(busy4 & !startc4), 32'd1);
    step();
    loadb4 = 1'b1;
    b_in   = 8'h01;
    exp4_q.push_back(9'd3);
    t = cyc;
    step();
    loadb4 = 1'b0;
    b_in   = 8'h00;
    @(negedge CLK);
    checkOutput("lateb_startc_u1", 32'(startc4), 32'd1);
    checkOutput("lateb_startc_cycle", 32'(cyc - t), 32'd1);
    waitDone4(done4 + 1);

    // Stray STARTA mid-A and LOADB mid-result must both be ignored.
    loadb4 = 1'b1;
    b_in   = 8'h06;
    step();
    loadb4 = 1'b0;
    b_in   = 8'h00;
    exp4_q.push_back(9'd17);
    for (int i = 0; i < 4; i++) begin
      starta4 = (i == 0 || i == 2);
      op_in   = (i == 2) ? 2'b01 : 2'b00;
      a_in    = (i == 2) ? 1'b0 : 1'b1;
      step();
    end
    starta4 = 1'b0;
    op_in   = 2'b00;
    a_in    = 1'b0;
    step();
    loadb4 = 1'b1;
    b_in   = 8'h09;
    step();
    loadb4 = 1'b0;
    b_in   = 8'h00;
    waitDone4(done4 + 1);
    sendA(4, 8'h03, 2'b00, 1'b0, 8'h00);
    @(negedge CLK);
    checkOutput("ign_waits_no_startc", 32'(startc4), 32'd0);
    checkOutput("ign_waits_busy", 32'(busy4), 32'd1);
    step();
    loadb4 = 1'b1;
    b_in   = 8'h04;
    exp4_q.push_back(9'd7);
    step();
    loadb4 = 1'b0;
    b_in   = 8'h00;
    @(negedge CLK);
    checkOutput("ign_startc_after_b", 32'(startc4), 32'd1);
    waitDone4(done4 + 1);

    // Reset while C carries bit 2 of R=4.
    loadb4 = 1'b1;
    b_in   = 8'h01;
    step();
    loadb4 = 1'b0;
    b_in   = 8'h00;
    exp4_q.push_back(9'd4);
    sendA(4, 8'h03, 2'b00, 1'b0, 8'h00);
    step();
    step();
    checkOutput("rst_c_bit2_before", 32'(c4), 32'd1);
    RESET_N = 1'b0;
    #1;
    checkOutput("rst_c_zero", 32'(c4), 32'd0);
    checkOutput("rst_startc_zero", 32'(startc4), 32'd0);
    checkOutput("rst_busy_zero", 32'(busy4), 32'd0);
    step();
    RESET_N = 1'b1;
    seen = 0;
    repeat (12) begin
      @(negedge CLK);
      if (startc4 || busy4) seen++;
    end
    checkOutput("rst_stays_idle", 32'(seen), 32'd0);
    step();
    sendA(4, 8'h05, 2'b00, 1'b0, 8'h00);
    @(negedge CLK);
    checkOutput("rst_bvalid_cleared", 32'(startc4), 32'd0);
    checkOutput("rst_new_op_busy", 32'(busy4), 32'd1);
    step();
    loadb4 = 1'b1;
    b_in   = 8'h02;
    exp4_q.push_back(9'd7);
    step();
    loadb4 = 1'b0;
    b_in   = 8'h00;
    @(negedge CLK);
    checkOutput("rst_new_op_startc", 32'(startc4), 32'd1);
    waitDone4(done4 + 1);

    // W=8 xor followed immediately by an add.
    loadb8 = 1'b1;
    b_in   = 8'hFF;
    step();
    loadb8 = 1'b0;
    b_in   = 8'h00;
    exp8_q.push_back(9'h05A);
    t = cyc;
    sendA(8, 8'hA5, 2'b11, 1'b0, 8'h00);
    @(negedge CLK);
    checkOutput("x8_startc", 32'(startc8), 32'd1);
    checkOutput("x8_startc_cycle", 32'(cyc - t), 32'd8);
    repeat (8) @(posedge CLK);
    @(negedge CLK);
    checkOutput("x8_busy_last_bit", 32'(busy8), 32'd1);
    step();
    checkOutput("x8_busy_gap", 32'(busy8), 32'd0);
    exp8_q.push_back(9'h122);
    t = cyc;
    sendA(8, 8'hC8, 2'b00, 1'b1, 8'h5A);
    @(negedge CLK);
    checkOutput("b2b_startc", 32'(startc8), 32'd1);
    checkOutput("b2b_startc_cycle", 32'(cyc - t), 32'd8);
    waitDone8(2);

    checkOutput("w4_queue_drained", 32'(exp4_q.size()), 32'd0);
    checkOutput("w8_queue_drained", 32'(exp8_q.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog timeout");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
